// File: rtl/datamux_pkg.sv
// datamux_pkg: shared sizing helper and page-slice function for the page multiplexer.
package datamux_pkg;

    localparam int MAXB = 1024;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Channels are packed low-first, so a page is a contiguous blk-bit field.
    function automatic logic [MAXB-1:0] page_slice(input logic [MAXB-1:0] d, input int page, input int blk);
        logic [MAXB-1:0] m;
        m = {MAXB{1'b1}} >> (MAXB - blk);
        return (d >> (page * blk)) & m;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts enabled cycles and ticks on the last cycle of each dwell period.
module dwell_timer
    import datamux_pkg::*;
#(
    parameter int DWELL = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = clog2(DWELL) > 0 ? clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && cnt_q == CW'(DWELL - 1);

    always_comb cnt_d = clr_i || tick_o ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk_i)
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;

endmodule

// File: rtl/datamux_scan.sv
// datamux_scan: registered page multiplexer with manual select or dwell-timed auto-scan.
module datamux_scan
    import datamux_pkg::*;
#(
    parameter int W = 4,
    parameter int N_CH = 4,
    parameter int N_OUT = 2,
    parameter int DWELL = 50_000_000,
    localparam int N_PAGE = N_CH / N_OUT,
    localparam int PW = clog2(N_PAGE) > 0 ? clog2(N_PAGE) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH*W-1:0] d_in_i,
    input  logic [PW-1:0]     sel_i,
    input  logic              auto_i,
    input  logic              hold_i,
    output logic [N_OUT*W-1:0] d_out_o,
    output logic [PW-1:0]     page_o,
    output logic              page_stb_o
);

    localparam int OW = N_OUT * W;
    localparam logic [PW:0] NP = (PW + 1)'(N_PAGE);

    logic          tick;
    logic [PW-1:0] sel_mod, page_nx, page_q;
    logic [OW-1:0] d_out_q, d_out_d;
    logic          stb_q, stb_d;

    // Manual mode holds the counter at zero, so entering auto always starts a fresh dwell.
    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (auto_i & ~hold_i),
        .clr_i  (~auto_i),
        .tick_o (tick)
    );

    always_comb begin
        sel_mod = {1'b0, sel_i} >= NP ? PW'({1'b0, sel_i} - NP) : sel_i;
        page_nx = !auto_i ? sel_mod : !tick ? page_q : page_q == PW'(N_PAGE - 1) ? '0 : page_q + PW'(1);
        d_out_d = OW'(page_slice(MAXB'(d_in_i), int'(page_nx), OW));
        stb_d   = page_nx != page_q;
    end

    always_ff @(posedge clk_i)
        if (rst_i) begin
            page_q  <= '0;
            d_out_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            page_q  <= page_nx;
            d_out_q <= d_out_d;
            stb_q   <= stb_d;
        end

    assign d_out_o    = d_out_q;
    assign page_o     = page_q;
    assign page_stb_o = stb_q;

endmodule
